// File: rtl/nibble_frame_tx.sv
// Transmit side of the nibble-serial framed link: IRQ pulse, preamble/SFD,
// RAM payload and a reflected CRC-32 trailer, one nibble per clock.
module nibble_frame_tx #(
    parameter int         PRE_NIBS  = 16,
    parameter int         DATA_NIBS = 30,
    parameter int         ADDR_W    = 8,
    parameter logic [3:0] PRE_NIB   = 4'h5,
    parameter logic [3:0] SFD_NIB   = 4'hD
) (
    input  logic              i_clk_125m,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_rden,
    input  logic [3:0]        i_ram_q,
    output logic              o_tx_irq,
    output logic              o_tx_valid,
    output logic [3:0]        o_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam int MAX_NIBS = (PRE_NIBS > DATA_NIBS) ? PRE_NIBS : DATA_NIBS;
    localparam int CNT_W    = ($clog2(MAX_NIBS) > 6) ? $clog2(MAX_NIBS) : 6;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_NIBS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NIBS - 1);

    typedef enum logic [2:0] {IDLE, IRQ, PRE, DATA, CRC, DONE} txState;

    txState            r_state, w_nextState;
    logic [CNT_W-1:0]  r_cnt, w_nextCnt;
    logic [2:0]        r_crcIdx, w_nextCrcIdx;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_crc, w_nextCrc, w_crcFold;
    logic              w_accept;
    logic              r_selRam;
    logic              r_txIrq, r_txValid, r_busy, r_done, r_aborted;
    logic              r_ramRden, w_ramRden;
    logic [ADDR_W-1:0] r_ramAddr, w_ramAddr;
    logic [3:0]        r_txData, w_txData;

    // Four LSB-first shift/XOR steps of the reflected CRC-32 LFSR.
    function automatic logic [31:0] crcStep4(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] v;
        v = c;
        for (int i = 0; i < 4; i++)
            v = (v[0] ^ d[i]) ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        return v;
    endfunction

    // Trailer nibble k of the complemented register, most significant group first
    // with each group bit-reversed (bit0 carries the higher register bit).
    function automatic logic [3:0] crcOutNib(input logic [31:0] crc, input logic [2:0] k);
        logic [31:0] s;
        s = (~crc) << {k, 2'b00};
        return {s[28], s[29], s[30], s[31]};
    endfunction

    assign w_crcFold = crcStep4(r_crc, i_ram_q);

    always_comb begin
        w_accept     = (r_state == IDLE) && i_start && !i_abort;
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextCrcIdx = r_crcIdx;
        w_nextCrc    = r_crc;
        w_ramRden    = 1'b0;
        w_ramAddr    = r_ramAddr;
        w_txData     = 4'h0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState  = IRQ;
                    w_nextCnt    = '0;
                    w_nextCrcIdx = '0;
                end
            end
            IRQ: begin
                w_nextState = PRE;
                w_nextCrc   = '1;
            end
            PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_nextState = DATA;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                w_nextCrc = w_crcFold;
                if (r_cnt == DATA_LAST)
                    w_nextState = CRC;
                else
                    w_nextCnt = r_cnt + CNT_W'(1);
            end
            CRC: begin
                if (r_crcIdx == 3'd7)
                    w_nextState = DONE;
                else
                    w_nextCrcIdx = r_crcIdx + 3'd1;
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase

        if (i_abort && (r_state != IDLE))
            w_nextState = IDLE;

        // Reads run one cycle ahead of the bus: base in the SFD cycle, then base+k+1.
        if ((w_nextState == PRE) && (w_nextCnt == PRE_LAST)) begin
            w_ramRden = 1'b1;
            w_ramAddr = r_base;
        end else if ((w_nextState == DATA) && (w_nextCnt != DATA_LAST)) begin
            w_ramRden = 1'b1;
            w_ramAddr = r_base + ADDR_W'(w_nextCnt) + ADDR_W'(1);
        end

        if (w_nextState == PRE)
            w_txData = (w_nextCnt == PRE_LAST) ? SFD_NIB : PRE_NIB;
        else if (w_nextState == CRC)
            w_txData = crcOutNib((r_state == DATA) ? w_crcFold : r_crc, w_nextCrcIdx);
    end

    always_ff @(posedge i_clk_125m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_crcIdx  <= '0;
            r_base    <= '0;
            r_crc     <= '1;
            r_selRam  <= 1'b0;
            r_txIrq   <= 1'b0;
            r_txValid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_ramRden <= 1'b0;
            r_ramAddr <= '0;
            r_txData  <= 4'h0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_crcIdx  <= w_nextCrcIdx;
            r_crc     <= w_nextCrc;
            if (w_accept)
                r_base <= i_base_addr;
            r_selRam  <= (w_nextState == DATA);
            r_txIrq   <= (w_nextState == IRQ);
            r_txValid <= (w_nextState == PRE) || (w_nextState == DATA) || (w_nextState == CRC);
            r_busy    <= (w_nextState != IDLE);
            r_done    <= (w_nextState == DONE);
            r_aborted <= i_abort && (r_state != IDLE);
            r_ramRden <= w_ramRden;
            r_ramAddr <= w_ramAddr;
            r_txData  <= w_txData;
        end
    end

    // Payload nibbles come straight from the RAM's registered output so that
    // nibble 0 lines up with the first DATA cycle.
    assign o_tx_data  = r_selRam ? i_ram_q : r_txData;
    assign o_tx_irq   = r_txIrq;
    assign o_tx_valid = r_txValid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_aborted  = r_aborted;
    assign o_ram_rden = r_ramRden;
    assign o_ram_addr = r_ramAddr;

endmodule

// File: tb/tb_nibble_frame_tx.sv
// Bench for nibble_frame_tx: table of frame scenarios with hand-derived
// timing/counts, an independent bit-serial CRC-32 model, plus corner sequences.
`timescale 1ns/1ps
module tb_nibble_frame_tx;

    localparam int PRE_NIBS   = 16;
    localparam int DATA_NIBS  = 30;
    localparam int FRAME_NIBS = PRE_NIBS + DATA_NIBS + 8;
    localparam int MAX_CYC    = 90;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef struct {
        string      name;
        logic [7:0] base;
        int         pattern;
        int         abortAt;
        int         expValid;
        int         expRden;
        int         expBusy;
        int         expDone;
        int         expAborted;
        int         expEndCyc;
    } frameVec;

    logic       clk125   = 1'b0;
    logic       rstN     = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] baseAddr = 8'h00;
    logic [7:0] ramAddr;
    logic       ramRden;
    logic [3:0] ramQ     = 4'h0;
    logic       irq, valid, busy, done, aborted;
    logic [3:0] data;
    logic [3:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    nibble_frame_tx dut (
        .i_clk_125m (clk125),
        .i_rst_n    (rstN),
        .i_start    (start),
        .i_abort    (abort),
        .i_base_addr(baseAddr),
        .o_ram_addr (ramAddr),
        .o_ram_rden (ramRden),
        .i_ram_q    (ramQ),
        .o_tx_irq   (irq),
        .o_tx_valid (valid),
        .o_tx_data  (data),
        .o_busy     (busy),
        .o_done     (done),
        .o_aborted  (aborted)
    );

    always #4 clk125 = ~clk125;

    // Synchronous RAM: data appears the cycle after the read request.
    always @(posedge clk125)
        if (ramRden)
            ramQ <= mem[ramAddr];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic s, input logic a, input logic [7:0] b);
        start    = s;
        abort    = a;
        baseAddr = b;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] outVec();
        return {14'd0, irq, valid, data, busy, done, aborted, ramRden, ramAddr};
    endfunction

    function automatic frameVec makeVec(input string n, input logic [7:0] b, input int p, input int ab,
                                        input int ev, input int er, input int eb, input int ed,
                                        input int ea, input int ec);
        frameVec v;
        v.name = n; v.base = b; v.pattern = p; v.abortAt = ab;
        v.expValid = ev; v.expRden = er; v.expBusy = eb; v.expDone = ed;
        v.expAborted = ea; v.expEndCyc = ec;
        return v;
    endfunction

    function automatic logic [3:0] payloadNib(input int pattern, input int k);
        case (pattern)
            0:       return 4'(k % 16);
            1:       return 4'h0;
            2:       return 4'hF;
            default: return 4'((k * 5 + 3) % 16);
        endcase
    endfunction

    // One bit of the reflected CRC-32 LFSR.
    function automatic logic [31:0] crcBit(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    endfunction

    task automatic runFrame(input frameVec v, input bit spam, input int tail);
        logic [3:0]  expNib [0:FRAME_NIBS-1];
        logic [3:0]  gotNib [0:FRAME_NIBS-1];
        logic [31:0] crc, r, rxR, res;
        logic [7:0]  expAddr;
        logic        abortNow;
        int nValid, nRden, nBusy, nIrq, nDone, nAborted;
        int irqCyc, firstValid, lastValid, endCyc, addrErr, preErr, payErr, lim;

        for (int a = 0; a < 256; a++)
            mem[a] = 4'((a * 7 + 9) % 16);
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < DATA_NIBS; k++) begin
            mem[v.base + 8'(k)] = payloadNib(v.pattern, k);
            for (int b = 0; b < 4; b++)
                crc = crcBit(crc, payloadNib(v.pattern, k) >> b);
        end
        r = ~crc;
        for (int i = 0; i < PRE_NIBS - 1; i++) expNib[i] = 4'h5;
        expNib[PRE_NIBS-1] = 4'hD;
        for (int k = 0; k < DATA_NIBS; k++) expNib[PRE_NIBS+k] = payloadNib(v.pattern, k);
        for (int k = 0; k < 8; k++)
            expNib[PRE_NIBS+DATA_NIBS+k] = {r[28-4*k], r[29-4*k], r[30-4*k], r[31-4*k]};
        for (int i = 0; i < FRAME_NIBS; i++) gotNib[i] = 4'h0;

        nValid = 0; nRden = 0; nBusy = 0; nIrq = 0; nDone = 0; nAborted = 0;
        irqCyc = -1; firstValid = -1; lastValid = -1; endCyc = -1; addrErr = 0;

        applyStimulus(1'b1, 1'b0, v.base);
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            @(negedge clk125);
            if (irq) begin nIrq++; irqCyc = cyc; end
            if (busy) nBusy++;
            if (valid) begin
                if (nValid < FRAME_NIBS) gotNib[nValid] = data;
                if (firstValid < 0) firstValid = cyc;
                lastValid = cyc;
                nValid++;
            end
            if (ramRden) begin
                expAddr = v.base + 8'(nRden);
                if (ramAddr !== expAddr) addrErr++;
                nRden++;
            end
            if (done) begin nDone++; endCyc = cyc; end
            if (aborted) begin nAborted++; endCyc = cyc; end
            abortNow = (v.abortAt >= 0) && valid && (nValid == PRE_NIBS + v.abortAt + 1);
            applyStimulus(spam && (endCyc < 0), abortNow, v.base);
            if ((endCyc >= 0) && (cyc >= endCyc + tail)) break;
        end
        applyStimulus(1'b0, 1'b0, v.base);

        preErr = 0; payErr = 0;
        lim = (nValid < PRE_NIBS + DATA_NIBS) ? nValid : PRE_NIBS + DATA_NIBS;
        for (int i = 0; i < lim; i++) begin
            if (gotNib[i] !== expNib[i]) begin
                if (i < PRE_NIBS) preErr++; else payErr++;
            end
        end

        checkOutput({v.name, " irq count"}, nIrq, 1);
        checkOutput({v.name, " irq cycle"}, irqCyc, 1);
        checkOutput({v.name, " valid count"}, nValid, v.expValid);
        checkOutput({v.name, " first valid cycle"}, firstValid, 2);
        checkOutput({v.name, " valid contiguous span"}, lastValid - firstValid + 1, nValid);
        checkOutput({v.name, " preamble nibble errors"}, preErr, 0);
        checkOutput({v.name, " payload nibble errors"}, payErr, 0);
        checkOutput({v.name, " rden count"}, nRden, v.expRden);
        checkOutput({v.name, " ram address errors"}, addrErr, 0);
        checkOutput({v.name, " busy cycles"}, nBusy, v.expBusy);
        checkOutput({v.name, " done count"}, nDone, v.expDone);
        checkOutput({v.name, " aborted count"}, nAborted, v.expAborted);
        checkOutput({v.name, " end pulse cycle"}, endCyc, v.expEndCyc);

        if (v.abortAt < 0) begin
            rxR = 32'h0;
            for (int k = 0; k < 8; k++)
                for (int b = 0; b < 4; b++)
                    rxR[31-4*k-b] = gotNib[PRE_NIBS+DATA_NIBS+k][b];
            checkOutput({v.name, " crc value"}, rxR, r);
            res = crc;
            for (int b = 0; b < 32; b++)
                res = crcBit(res, rxR[b]);
            checkOutput({v.name, " receiver crc residue"}, res, RESIDUE);
        end
    endtask

    initial begin
        frameVec vecs [0:5];
        frameVec spamVec, b2bVec, postResetVec;

        vecs[0] = makeVec("count base 00",   8'h00, 0, -1, 54, 30, 56, 1, 0, 56);
        vecs[1] = makeVec("all zero",        8'h00, 1, -1, 54, 30, 56, 1, 0, 56);
        vecs[2] = makeVec("all ones",        8'h20, 2, -1, 54, 30, 56, 1, 0, 56);
        vecs[3] = makeVec("wrap base F0",    8'hF0, 0, -1, 54, 30, 56, 1, 0, 56);
        vecs[4] = makeVec("abort nibble 10", 8'h00, 0, 10, 27, 12, 28, 0, 1, 29);
        vecs[5] = makeVec("after abort",     8'h40, 3, -1, 54, 30, 56, 1, 0, 56);
        spamVec      = makeVec("start spam",       8'h08, 3, -1, 54, 30, 56, 1, 0, 56);
        b2bVec       = makeVec("back to back",     8'h08, 0, -1, 54, 30, 56, 1, 0, 56);
        postResetVec = makeVec("after mid reset",  8'h80, 2, -1, 54, 30, 56, 1, 0, 56);

        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk125);
        checkOutput("outputs during reset", outVec(), 32'h0);
        rstN = 1'b1;
        @(negedge clk125);
        checkOutput("idle after reset", outVec(), 32'h0);

        applyStimulus(1'b0, 1'b1, 8'h00);
        @(negedge clk125);
        checkOutput("abort in idle ignored", {30'd0, aborted, busy}, 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h00);
        @(negedge clk125);
        checkOutput("start with abort ignored", {30'd0, irq, busy}, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge clk125);
        checkOutput("still idle", {31'd0, busy}, 32'h0);

        for (int i = 0; i < 6; i++)
            runFrame(vecs[i], 1'b0, 3);

        runFrame(spamVec, 1'b1, 0);
        @(negedge clk125);
        checkOutput("idle gap after done", {30'd0, irq, busy}, 32'h0);
        runFrame(b2bVec, 1'b0, 3);

        $display("[TB] reset during CRC trailer");
        applyStimulus(1'b1, 1'b0, 8'h10);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk125);
            applyStimulus(1'b0, 1'b0, 8'h10);
        end
        checkOutput("valid before mid-crc reset", {31'd0, valid}, 32'h1);
        #1 rstN = 1'b0;
        #1 checkOutput("outputs at reset assertion", outVec(), 32'h0);
        @(negedge clk125);
        checkOutput("outputs held in reset", outVec(), 32'h0);
        rstN = 1'b1;
        @(negedge clk125);
        checkOutput("idle after mid-frame reset", outVec(), 32'h0);
        runFrame(postResetVec, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
